// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store controller sitting in front of a
// word-wide data memory whose read data is registered (valid one cycle after
// dm_rd). Byte/half/word loads are lane-extracted and sign/zero-extended.
// Sub-word stores are done as read-modify-write because the memory only
// writes whole words.
//
// Optional feature macro: LSU_ALIGN_CHECK_EN
//   defined   : misaligned or out-of-range requests take an error response
//   undefined : offsets are forced to natural alignment, upper address bits
//               are ignored, resp_err is tied low and no error state exists
module load_store_unit #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_rd,
  output logic              dm_wr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3
`ifdef LSU_ALIGN_CHECK_EN
    , S_ERR = 3'd4
`endif
  } state_t;

  state_t state, next_state;

  // Request fields captured on acceptance
  logic        q_we;
  logic        q_word;
  logic        q_half;
  logic        q_signed;
  logic [1:0]  q_off;
  logic [31:0] q_wdata;

  logic        req_word;
  logic        req_half;
  logic [1:0]  req_off;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  // Size 11 is handled exactly like a word access.
  assign req_word = req_size[1];
  assign req_half = (req_size == 2'b01);

`ifdef LSU_ALIGN_CHECK_EN
  logic req_bad;
  assign req_bad = (req_half && req_addr[0])
                || (req_word && (req_addr[1:0] != 2'b00))
                || (req_addr[31:ADDR_W+2] != '0);
`else
  // Upper address bits are intentionally dropped in this build.
  logic unused_addr_bits;
  assign unused_addr_bits = |req_addr[31:ADDR_W+2];
`endif

  // dm strobes and ready come straight from the state register only.
  assign req_ready = (state == S_IDLE);
  assign dm_rd     = (state == S_RD);
  assign dm_wr     = (state == S_WR);

  // Force the in-word offset to the natural alignment of the access size
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    req_off = req_addr[1:0];
    if (req_word)      req_off = 2'b00;
    else if (req_half) req_off[0] = 1'b0;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
`ifdef LSU_ALIGN_CHECK_EN
          if (req_bad)                   next_state = S_ERR;
          else
`endif
          if (!req_we || !req_word)      next_state = S_RD;
          else                           next_state = S_WR;
        end
      end
      S_RD:    next_state = S_CAP;
      S_CAP:   next_state = q_we ? S_WR : S_IDLE;
      S_WR:    next_state = S_IDLE;
`ifdef LSU_ALIGN_CHECK_EN
      S_ERR:   next_state = S_IDLE;
`endif
      default: next_state = S_IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    lane_byte  = dm_rdata[{q_off, 3'b000} +: 8];
    lane_half  = dm_rdata[{q_off[1], 4'b0000} +: 16];
    load_data  = dm_rdata;
    merge_data = dm_rdata;
    if (q_half) begin
      load_data = {{16{q_signed & lane_half[15]}}, lane_half};
      merge_data[{q_off[1], 4'b0000} +: 16] = q_wdata[15:0];
    end else if (!q_word) begin
      load_data = {{24{q_signed & lane_byte[7]}}, lane_byte};
      merge_data[{q_off, 3'b000} +: 8] = q_wdata[7:0];
    end
  end

  // Request capture, dm address/data registers and response generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_we       <= 1'b0;
      q_word     <= 1'b0;
      q_half     <= 1'b0;
      q_signed   <= 1'b0;
      q_off      <= 2'b00;
      q_wdata    <= 32'h0;
      dm_addr    <= '0;
      dm_wdata   <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            q_we     <= req_we;
            q_word   <= req_word;
            q_half   <= req_half;
            q_signed <= req_signed;
            q_off    <= req_off;
            q_wdata  <= req_wdata;
            dm_addr  <= req_addr[ADDR_W+1:2];
            if (req_we && req_word) dm_wdata <= req_wdata;
          end
        end
        S_CAP: begin
          if (q_we) begin
            dm_wdata <= merge_data;
          end else begin
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
          end
        end
        S_WR: resp_valid <= 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
        S_ERR: resp_valid <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  // Error flag accompanies the response pulse of a rejected request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp_err <= 1'b0;
    else        resp_err <= (state == S_ERR);
  end
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: self-checking bench for load_store_unit. A word-wide
// data memory with registered read sits behind the DUT; a byte-array
// reference model predicts load data, error flags, latency and final memory.
module tb_load_store_unit;

  localparam int ADDR_W = 7;
  localparam int WORDS  = 1 << ADDR_W;
  localparam int BYTES  = WORDS * 4;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] dm_addr;
  logic              dm_rd;
  logic              dm_wr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;

  int n_checks   = 0;
  int n_pass     = 0;
  int resp_count = 0;
  int wr_count   = 0;

  logic [31:0] dm_mem  [WORDS];
  logic [7:0]  ref_mem [BYTES];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dm_addr    (dm_addr),
    .dm_rd      (dm_rd),
    .dm_wr      (dm_wr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: whole-word write, read data registered one cycle after dm_rd
  initial begin
    for (int i = 0; i < WORDS; i++) dm_mem[i] = 32'h0;
    dm_rdata <= 32'h0;
    forever begin
      @(posedge clk);
      if (dm_rd) dm_rdata <= dm_mem[dm_addr];
      if (dm_wr) dm_mem[dm_addr] = dm_wdata;
    end
  end

  // Count response pulses and write cycles
  always @(negedge clk) begin
    if (resp_valid) resp_count <= resp_count + 1;
    if (dm_wr)      wr_count   <= wr_count + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference model: byte-addressed memory, rules applied directly
  task automatic model_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat);
    int n;
    int a;
    logic [31:0] v;
    n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    rdata = 32'h0;
    a     = int'(addr & 32'(BYTES - 1));
`ifdef LSU_ALIGN_CHECK_EN
    err = ((a % n) != 0) || (addr >= 32'(BYTES));
`else
    err = 1'b0;
    a   = a - (a % n);
`endif
    if (err) begin
      lat = 1;
    end else if (we) begin
      for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[8*i +: 8];
      lat = (n == 4) ? 1 : 3;
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
      if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      rdata = v;
      lat   = 2;
    end
  endtask

  // Drive one request, wait (bounded) for its response, observe dm activity
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic got, output logic [31:0] rdata, output logic err,
                         output int lat, output int rdc, output int wrc,
                         output logic [ADDR_W-1:0] wra);
    int guard;
    guard = 0;
    got = 1'b0; rdata = 32'h0; err = 1'b0; lat = 0; rdc = 0; wrc = 0; wra = '0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!got && lat < 10) begin
      if (dm_rd) rdc++;
      if (dm_wr) begin
        wrc++;
        wra = dm_addr;
      end
      @(posedge clk);
      lat++;
      #1;
      if (resp_valid) begin
        got   = 1'b1;
        rdata = resp_rdata;
        err   = resp_err;
      end
    end
  endtask

  task automatic txn_check(input string tag, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    logic got, err;
    logic [31:0] rdata;
    int lat, rdc, wrc;
    logic [ADDR_W-1:0] wra;
    logic exp_rd, exp_wr;
    run_req(we, size, sgn, addr, wdata, got, rdata, err, lat, rdc, wrc, wra);
    exp_rd = !exp_err && (!we || !size[1]);
    exp_wr = !exp_err && we;
    check($sformatf("%s_resp_seen", tag), 32'(got), 32'd1);
    if (got) begin
      check($sformatf("%s_rdata", tag), rdata, exp_rdata);
      check($sformatf("%s_err", tag), 32'(err), 32'(exp_err));
      check($sformatf("%s_latency", tag), 32'(lat), 32'(exp_lat));
      check($sformatf("%s_rd_cycles", tag), 32'(rdc), 32'(exp_rd));
      check($sformatf("%s_wr_cycles", tag), 32'(wrc), 32'(exp_wr));
      if (exp_wr) check($sformatf("%s_wr_index", tag), 32'(wra), 32'(addr[ADDR_W+1:2]));
    end
  endtask

  initial begin
    vec_t vecs [13];
    logic [31:0] m_rdata, m_exp;
    logic        m_err;
    int          m_lat;
    int          rc0, wc0;
    logic        saw_resp;
    logic        r_we, r_sgn;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata;

    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;

    vecs[0]  = '{1'b1, 2'd2, 1'b1, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0, 1};
    vecs[1]  = '{1'b0, 2'd2, 1'b1, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h010, 32'h11223344, 32'h0,        1'b0, 1};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h013, 32'h123456A5, 32'h0,        1'b0, 3};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hA5223344, 1'b0, 2};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h013, 32'h0,        32'hFFFFFFA5, 1'b0, 2};
    vecs[6]  = '{1'b0, 2'd0, 1'b0, 32'h013, 32'h0,        32'h000000A5, 1'b0, 2};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h012, 32'h0,        32'hFFFFA522, 1'b0, 2};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h000, 32'h00008001, 32'h0,        1'b0, 1};
`ifdef LSU_ALIGN_CHECK_EN
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h011, 32'h0,        32'h0,        1'b1, 1};
    vecs[10] = '{1'b0, 2'd1, 1'b1, 32'h201, 32'h0,        32'h0,        1'b1, 1};
`else
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h011, 32'h0,        32'hA5223344, 1'b0, 2};
    vecs[10] = '{1'b0, 2'd1, 1'b1, 32'h201, 32'h0,        32'hFFFF8001, 1'b0, 2};
`endif
    vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h002, 32'h1234BEEF, 32'h0,        1'b0, 3};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h000, 32'h0,        32'hBEEF8001, 1'b0, 2};

    // Reset values
    #3 rst_n = 1'b0;
    #4;
    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata,      32'd0);
    check("rst_resp_err",   32'(resp_err),   32'd0);
    check("rst_dm_rd",      32'(dm_rd),      32'd0);
    check("rst_dm_wr",      32'(dm_wr),      32'd0);
    check("rst_dm_addr",    32'(dm_addr),    32'd0);
    check("rst_dm_wdata",   dm_wdata,        32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      model_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                m_rdata, m_err, m_lat);
      txn_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].sgn,
                vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err,
                vecs[i].exp_lat);
    end

    // Held request through a read-modify-write, then a second request
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h014; req_wdata = 32'h0000005A;
    @(posedge clk); #1;
    rc0 = resp_count;
    model_req(1'b1, 2'd0, 1'b0, 32'h014, 32'h0000005A, m_rdata, m_err, m_lat);
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h014; req_wdata = 32'h0;
    check("hold_ready_e0", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("hold_ready_e1", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("hold_ready_e2", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("hold_ready_e3", 32'(req_ready), 32'd1);
    check("hold_resp_e3",  32'(resp_valid), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("hold_accept2_ready", 32'(req_ready), 32'd0);
    check("hold_no_dup_resp",   32'(resp_valid), 32'd0);
    model_req(1'b0, 2'd2, 1'b0, 32'h014, 32'h0, m_exp, m_err, m_lat);
    @(posedge clk); #1;
    check("hold_load_pending", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    check("hold_load_resp",  32'(resp_valid), 32'd1);
    check("hold_load_rdata", resp_rdata, m_exp);
    @(negedge clk); #1;
    check("hold_resp_count", 32'(resp_count - rc0), 32'd2);

    // Reset during CAP of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h011; req_wdata = 32'h00000077;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wc0 = wr_count;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_dm_rd", 32'(dm_rd), 32'd0);
    check("abort_dm_wr", 32'(dm_wr), 32'd0);
    saw_resp = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      if (resp_valid) saw_resp = 1'b1;
    end
    check("abort_no_resp", 32'(saw_resp), 32'd0);
    check("abort_no_write", 32'(wr_count - wc0), 32'd0);
    model_req(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, m_rdata, m_err, m_lat);
    txn_check("abort_reload", 1'b0, 2'd2, 1'b0, 32'h010, 32'h0, m_rdata, m_err, m_lat);

    // Randomized traffic against the reference model
    for (int t = 0; t < 300; t++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_size  = 2'($urandom_range(0, 3));
      r_sgn   = 1'($urandom_range(0, 1));
      r_wdata = $urandom;
      case ($urandom_range(0, 3))
        0:       r_addr = $urandom;
        1:       r_addr = 32'($urandom_range(0, 63));
        default: r_addr = 32'($urandom_range(0, BYTES - 1));
      endcase
      model_req(r_we, r_size, r_sgn, r_addr, r_wdata, m_rdata, m_err, m_lat);
      txn_check($sformatf("rnd%0d", t), r_we, r_size, r_sgn, r_addr, r_wdata,
                m_rdata, m_err, m_lat);
    end

    // Final memory image
    repeat (2) @(negedge clk);
    for (int w = 0; w < WORDS; w++) begin
      m_exp = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
      check($sformatf("mem_w%0d", w), dm_mem[w], m_exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
